// File: rtl/pwm_capture.sv
// PWM capture: synchronises pwm_in, measures high time and period between
// consecutive rising edges, and flags a stuck line after TIMEOUT cycles.
module pwm_capture #(
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] high_count,
  output logic [CNT_WIDTH-1:0] period_count,
  output logic                 sample_valid,
  output logic                 stuck,
  output logic                 stuck_level
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE         = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ZERO        = {CNT_WIDTH{1'b0}};

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic                 prev;
  logic [CNT_WIDTH-1:0] period_acc;
  logic [CNT_WIDTH-1:0] high_acc;
  logic                 rise;
  logic                 timeout_hit;

  // Synchroniser resets high so a line already high at release is not a rise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= pwm_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Edge and timeout decode.
  always_comb begin
    rise        = 1'b0;
    timeout_hit = 1'b0;
    rise        = sync2 & ~prev;
    timeout_hit = (period_acc == TIMEOUT_VAL);
  end

  // Measurement state machine; accumulators only count while measuring,
  // so period_acc stops at TIMEOUT and never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      period_acc   <= ZERO;
      high_acc     <= ZERO;
      high_count   <= ZERO;
      period_count <= ZERO;
      sample_valid <= 1'b0;
      stuck        <= 1'b0;
      stuck_level  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            period_acc <= ONE;
            high_acc   <= ONE;
            stuck      <= 1'b0;
            state      <= MEASURE;
          end else begin
            state <= IDLE;
          end
        end
        MEASURE: begin
          if (rise) begin
            high_count   <= high_acc;
            period_count <= period_acc;
            sample_valid <= 1'b1;
            period_acc   <= ONE;
            high_acc     <= ONE;
          end else if (timeout_hit) begin
            stuck        <= 1'b1;
            stuck_level  <= sync2;
            period_count <= TIMEOUT_VAL;
            high_count   <= sync2 ? TIMEOUT_VAL : ZERO;
            sample_valid <= 1'b1;
            state        <= STUCK;
          end else begin
            period_acc <= period_acc + ONE;
            high_acc   <= high_acc + {{(CNT_WIDTH-1){1'b0}}, sync2};
          end
        end
        STUCK: begin
          if (rise) begin
            stuck      <= 1'b0;
            period_acc <= ONE;
            high_acc   <= ONE;
            state      <= MEASURE;
          end else begin
            state <= STUCK;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: each scenario plans a level sequence, derives the
// expected samples from rise positions, then plays it and checks each pulse.
module tb_pwm_capture;
  localparam int CW = 16;
  localparam int T  = 100;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pwm_in = 1'b1;
  logic [CW-1:0] high_count;
  logic [CW-1:0] period_count;
  logic          sample_valid;
  logic          stuck;
  logic          stuck_level;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    int hc;
    int pc;
    bit st;
    bit sl;
  } exp_t;

  bit   plan[$];
  exp_t expq[$];

  always #5 clock = ~clock;

  pwm_capture #(.CNT_WIDTH(CW), .TIMEOUT(T)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pwm_in       (pwm_in),
    .high_count   (high_count),
    .period_count (period_count),
    .sample_valid (sample_valid),
    .stuck        (stuck),
    .stuck_level  (stuck_level)
  );

  task automatic add_pattern(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) plan.push_back(1'b1);
      repeat (l) plan.push_back(1'b0);
    end
  endtask

  task automatic add_hold(input bit v, input int n);
    repeat (n) plan.push_back(v);
  endtask

  // Reference: a sample at every rise following an earlier rise (unless stuck
  // in between); a stuck report when T cycles pass after a rise with no rise.
  task automatic build_expected(output bit fin_stuck);
    int last;
    bit stk;
    int lim;
    bit rise;
    int h;
    last = -1;
    stk  = 1'b0;
    lim  = plan.size() - 4;
    expq.delete();
    for (int i = 1; i <= lim; i++) begin
      rise = plan[i] && !plan[i-1];
      if (rise) begin
        if (last >= 0 && !stk) begin
          h = 0;
          for (int j = last; j < i; j++) h += int'(plan[j]);
          expq.push_back('{i, h, i - last, 1'b0, 1'b0});
        end
        last = i;
        stk  = 1'b0;
      end else if (last >= 0 && !stk && (i - last) == T) begin
        expq.push_back('{i, plan[i] ? T : 0, T, 1'b1, plan[i]});
        stk = 1'b1;
      end
    end
    fin_stuck = stk;
  endtask

  // plan[0] is the level held through reset release; pulses for decision
  // index j appear at the negedge after index j+3 is driven.
  task automatic run_plan(output bit fin_stuck);
    exp_t e;
    int   played;
    build_expected(fin_stuck);
    reset_n = 1'b0;
    pwm_in  = plan[0];
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 1; i < plan.size(); i++) begin
      @(posedge clock);
      #1;
      pwm_in = plan[i];
      played = i + 1;
      @(negedge clock);
      if (sample_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: pulse at index %0d, expected none", played - 4);
        end else begin
          e = expq.pop_front();
          if ((played - 4) !== e.idx || high_count !== CW'(e.hc) ||
              period_count !== CW'(e.pc) || stuck !== e.st ||
              (e.st && stuck_level !== e.sl)) begin
            errors++;
            $display("FAIL sample: got idx=%0d high=%0d period=%0d stuck=%0b lvl=%0b, expected idx=%0d high=%0d period=%0d stuck=%0b lvl=%0b",
                     played - 4, high_count, period_count, stuck, stuck_level,
                     e.idx, e.hc, e.pc, e.st, e.sl);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    pwm_in  = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (high_count !== 16'd0 || period_count !== 16'd0 || sample_valid !== 1'b0 ||
        stuck !== 1'b0 || stuck_level !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got hc=%0d pc=%0d v=%0b st=%0b sl=%0b, expected all 0",
               high_count, period_count, sample_valid, stuck, stuck_level);
    end
  endtask

  task automatic test_normal;
    bit fin;
    plan.delete();
    plan.push_back(1'b0);
    add_hold(1'b0, 4);
    add_pattern(5, 11, 8);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin) begin
      errors++;
      $display("FAIL normal_end: got missing=%0d stuck=%0b, expected missing=0 stuck=%0b",
               expq.size(), stuck, fin);
    end
    checks++;
    if (high_count !== 16'd5 || period_count !== 16'd16) begin
      errors++;
      $display("FAIL normal_value: got hc=%0d pc=%0d, expected hc=5 pc=16", high_count, period_count);
    end
  endtask

  task automatic test_release_high;
    bit fin;
    plan.delete();
    plan.push_back(1'b1);
    add_hold(1'b1, 6);
    add_pattern(3, 7, 6);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin || high_count !== 16'd3 || period_count !== 16'd10) begin
      errors++;
      $display("FAIL release_high: got missing=%0d stuck=%0b hc=%0d pc=%0d, expected 0 %0b 3 10",
               expq.size(), stuck, high_count, period_count, fin);
    end
  endtask

  task automatic test_stuck;
    bit fin;
    plan.delete();
    plan.push_back(1'b0);
    add_pattern(6, 14, 3);
    add_hold(1'b1, 1);
    add_hold(1'b0, 150);
    add_pattern(6, 14, 3);
    add_hold(1'b1, 150);
    add_hold(1'b0, 5);
    add_pattern(6, 14, 2);
    add_hold(1'b0, 4);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin) begin
      errors++;
      $display("FAIL stuck_end: got missing=%0d stuck=%0b, expected missing=0 stuck=%0b",
               expq.size(), stuck, fin);
    end
  endtask

  task automatic test_duty_extremes;
    bit fin;
    plan.delete();
    plan.push_back(1'b0);
    add_pattern(1, 19, 4);
    add_pattern(19, 1, 4);
    add_hold(1'b1, 1);
    add_hold(1'b0, 4);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin || high_count !== 16'd19 || period_count !== 16'd20) begin
      errors++;
      $display("FAIL duty_extremes: got missing=%0d stuck=%0b hc=%0d pc=%0d, expected 0 %0b 19 20",
               expq.size(), stuck, high_count, period_count, fin);
    end
  endtask

  task automatic test_timeout_edge;
    bit fin;
    plan.delete();
    plan.push_back(1'b0);
    add_pattern(30, 70, 3);
    add_pattern(30, 71, 2);
    add_pattern(30, 70, 2);
    add_hold(1'b1, 1);
    add_hold(1'b0, 4);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin || period_count !== 16'd100) begin
      errors++;
      $display("FAIL timeout_edge: got missing=%0d stuck=%0b pc=%0d, expected 0 %0b 100",
               expq.size(), stuck, period_count, fin);
    end
  endtask

  task automatic test_random;
    bit fin;
    int total;
    plan.delete();
    plan.push_back(1'($urandom_range(0, 1)));
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 5))
        0: add_hold(1'($urandom_range(0, 1)), $urandom_range(90, 140));
        1: begin
          total = $urandom_range(99, 101);
          add_pattern($urandom_range(1, 40), total - 40, 1);
        end
        default: add_pattern($urandom_range(1, 45), $urandom_range(1, 45), 1);
      endcase
    end
    add_pattern(4, 4, 2);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin) begin
      errors++;
      $display("FAIL random_end: got missing=%0d stuck=%0b, expected missing=0 stuck=%0b",
               expq.size(), stuck, fin);
    end
  endtask

  task automatic test_reset_mid;
    bit fin;
    plan.delete();
    plan.push_back(1'b0);
    add_pattern(5, 11, 4);
    add_pattern(5, 3, 1);
    run_plan(fin);
    checks++;
    if (high_count !== 16'd5 || period_count !== 16'd16) begin
      errors++;
      $display("FAIL reset_mid_pre: got hc=%0d pc=%0d, expected hc=5 pc=16", high_count, period_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (high_count !== 16'd0 || period_count !== 16'd0 || sample_valid !== 1'b0 || stuck !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got hc=%0d pc=%0d v=%0b st=%0b, expected all 0",
               high_count, period_count, sample_valid, stuck);
    end
    plan.delete();
    plan.push_back(1'b1);
    add_hold(1'b1, 2);
    add_pattern(7, 9, 4);
    add_hold(1'b1, 1);
    add_hold(1'b0, 4);
    run_plan(fin);
    checks++;
    if (expq.size() != 0 || stuck !== fin || high_count !== 16'd7 || period_count !== 16'd16) begin
      errors++;
      $display("FAIL reset_mid_resume: got missing=%0d stuck=%0b hc=%0d pc=%0d, expected 0 %0b 7 16",
               expq.size(), stuck, high_count, period_count, fin);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_release_high();
    test_stuck();
    test_duty_extremes();
    test_timeout_edge();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform, the receive-side counterpart of the team's PWM generators (e.g. the 4-bit counter/comparator PWM driving LEDs on the iCEstick).
- Synchronises the external pwm_in, measures high time and period in clock cycles between consecutive rising edges, and presents each completed measurement with a one-cycle valid strobe.
- Detects a stuck line, i.e. 0% or 100% duty, through a timeout.
- Used for loopback self-test of the on-board PWM generators and for reading external PWM sources.

Parameters:
CNT_WIDTH, 16, width of the measurement counters and of both count outputs.
TIMEOUT, 65535, cycles without a rising edge before the line is declared stuck; legal range 2 .. 2^CNT_WIDTH-1.

Ports:
clock  input  1  single system clock, all logic on the posedge
reset_n  input  1  asynchronous, active-low reset
pwm_in  input  1  asynchronous PWM input
high_count  output  CNT_WIDTH  high cycles of the last completed period
period_count  output  CNT_WIDTH  length of the last completed period in cycles
sample_valid  output  1  one-cycle pulse when high_count/period_count update
stuck  output  1  line has had no rising edge for TIMEOUT cycles
stuck_level  output  1  synchronised line level when stuck was declared

Behaviour:
- Interface: single clock "clock"; reset "reset_n" is asynchronous and active-low, all flops clear immediately on its assertion.
- Input path:
  - 2-flop synchroniser sync1→sync2, then a registered copy prev.
  - rise = sync2 & ~prev. A pwm_in rising edge therefore produces rise 2–3 cycles later.
  - sync1, sync2 and prev reset to 1, so a line held high through reset release produces no false rise.
- Reset values: high_count=0, period_count=0, sample_valid=0, stuck=0, stuck_level=0, state=IDLE, both accumulators=0.
- Accumulators: period_acc and high_acc, CNT_WIDTH bits each.
  - On a rise cycle: both load 1.
  - Otherwise: period_acc += 1 and high_acc += sync2.
  - period_acc never exceeds TIMEOUT, so no saturation logic is needed. high_acc ≤ period_acc.
  - For a line high H and low L cycles: high_count=H, period_count=H+L.
- State machine:
  - IDLE: waits for rise, ignoring any partial first period. On rise: load accumulators, go to MEASURE, clear stuck.
  - MEASURE, on rise: register high_count←high_acc, period_count←period_acc, sample_valid=1 for that cycle, reload accumulators, stay in MEASURE.
  - MEASURE, no rise and period_acc==TIMEOUT: go to STUCK.
  - STUCK entry cycle:
    - stuck←1, stuck_level←sync2.
    - period_count←TIMEOUT; high_count←TIMEOUT if sync2 else 0.
    - sample_valid pulses once.
  - STUCK, waiting: no further pulses while stuck.
  - STUCK, on rise: stuck←0, load accumulators, go to MEASURE. The first new sample arrives at the following rise.
- Latency: sample_valid asserts in the same cycle the terminating rise is detected; outputs are registered and hold until the next update.
- Simultaneous events: rise takes priority over timeout in the same cycle, so the sample is reported and stuck is not declared.
- Reset mid-measurement: all state is discarded and outputs return to reset values. Valid data resumes only after two rising edges.
- Minimum measurable pulse is 1 clock high or low. Narrower pulses may be missed, with no error flag.

Test Plan:
- Normal sample: pwm_in repeating 5 cycles high / 11 low (matches a 4-bit generator at value 5) → after the second rise, sample_valid pulses every 16 cycles with high_count=5, period_count=16, stuck=0.
- Release with line high: reset_n released with pwm_in held high, then 3 high / 7 low pattern → no pulse before the second detected rise; first sample high_count=3, period_count=10, never a partial period.
- Stuck low: TIMEOUT=100, pattern stopped with pwm_in low → exactly one pulse 100 cycles after the last rise with stuck=1, stuck_level=0, high_count=0, period_count=100; no further pulses. A later rise clears stuck, and next period reports correctly.
- Stuck high: TIMEOUT=100, pwm_in held high → single pulse, stuck_level=1, high_count=100, period_count=100.
- Duty extremes: 1 high / 19 low → high_count=1, period_count=20; 19 high / 1 low → high_count=19, period_count=20.
- Rise on timeout cycle: rise lands exactly when period_acc==TIMEOUT → normal sample reported, stuck stays 0.
- Reset mid-period: reset_n pulsed low mid-period → outputs 0 immediately (asynchronous); first pulse after two subsequent rises.
